// File: rtl/rocket_pool_move.sv
// Pool of independent fixed-point rockets fired from one tank. Each new shot
// takes the lowest free slot, and each slot is retired on a hit, on leaving the frame, on lifetime expiry or on tank death.
module rocket_pool_move #(
   parameter int NUM_ROCKETS     = 4,
   parameter int XSPEED          = 100,
   parameter int YSPEED          = 100,
   parameter int FRAC_BITS       = 6,
   parameter int X_MAX           = 543,
   parameter int Y_MAX           = 479,
   parameter int MUZZLE_OFFSET   = 12,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int LIFETIME_FRAMES = 0
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       startOfFrame,
   input  logic                       shoot,
   input  logic [1:0]                 last_direction,
   input  logic [10:0]                tankX,
   input  logic [10:0]                tankY,
   input  logic [NUM_ROCKETS-1:0]     hit,
   input  logic                       tank_death,
   output logic [11*NUM_ROCKETS-1:0]  topLeftX,
   output logic [11*NUM_ROCKETS-1:0]  topLeftY,
   output logic [2*NUM_ROCKETS-1:0]   direction,
   output logic [NUM_ROCKETS-1:0]     rocket_enable,
   output logic                       fire_ack,
   output logic                       pool_full
);

   localparam int POS_W = 12 + FRAC_BITS;
   localparam int AGE_W = 16;
   localparam int CD_W  = 16;

   typedef logic signed [POS_W-1:0] pos_t;

   localparam pos_t X_LIM  = pos_t'(X_MAX * (2 ** FRAC_BITS));
   localparam pos_t Y_LIM  = pos_t'(Y_MAX * (2 ** FRAC_BITS));
   localparam pos_t X_STEP = pos_t'(XSPEED);
   localparam pos_t Y_STEP = pos_t'(YSPEED);

   typedef enum logic [1:0] {IDLE, LAUNCH, FLY} slotState_e;

   slotState_e             state_q  [NUM_ROCKETS];
   slotState_e             state_d  [NUM_ROCKETS];
   pos_t                   posX_q   [NUM_ROCKETS];
   pos_t                   posX_d   [NUM_ROCKETS];
   pos_t                   posY_q   [NUM_ROCKETS];
   pos_t                   posY_d   [NUM_ROCKETS];
   logic [1:0]             dir_q    [NUM_ROCKETS];
   logic [1:0]             dir_d    [NUM_ROCKETS];
   logic [AGE_W-1:0]       age_q    [NUM_ROCKETS];
   logic [AGE_W-1:0]       age_d    [NUM_ROCKETS];

   logic                   shoot_q;
   logic [CD_W-1:0]        cooldown_q;
   logic [CD_W-1:0]        cooldown_d;
   logic [NUM_ROCKETS-1:0] idleVec;
   logic [NUM_ROCKETS-1:0] allocOH;
   logic [NUM_ROCKETS-1:0] launching;
   logic                   req;
   logic                   grant;
   pos_t                   launchX;
   pos_t                   launchY;

   // Allocation looks only at registered state, so a slot freed this cycle
   // cannot be reused until the next one. Scanning downward leaves the lowest idle slot selected.
   always_comb begin
      idleVec = '0;
      allocOH = '0;
      for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
         if (state_q[i] == IDLE) begin
            idleVec[i] = 1'b1;
            allocOH    = '0;
            allocOH[i] = 1'b1;
         end
      end
   end

   assign req       = shoot & ~shoot_q;
   assign grant     = req & (cooldown_q == '0) & (|idleVec) & ~tank_death;
   assign launchX   = (pos_t'(tankX) + pos_t'(MUZZLE_OFFSET)) <<< FRAC_BITS;
   assign launchY   = (pos_t'(tankY) + pos_t'(MUZZLE_OFFSET)) <<< FRAC_BITS;
   assign fire_ack  = |launching;
   assign pool_full = ~|idleVec;

   // A fresh load beats the per-frame decrement; tank death wipes the cooldown.
   always_comb begin
      cooldown_d = cooldown_q;
      if (tank_death)
         cooldown_d = '0;
      else if (grant)
         cooldown_d = CD_W'(COOLDOWN_FRAMES);
      else if (startOfFrame && (cooldown_q != '0))
         cooldown_d = cooldown_q - 1'b1;
   end

   // Per-slot next state. A move that would leave the frame retires the slot
   // and keeps the last in-bounds position on the outputs.
   always_comb begin
      pos_t nextPos;
      pos_t limit;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
         state_d[i] = state_q[i];
         posX_d[i]  = posX_q[i];
         posY_d[i]  = posY_q[i];
         dir_d[i]   = dir_q[i];
         age_d[i]   = age_q[i];
         nextPos    = '0;
         limit      = dir_q[i][0] ? X_LIM : Y_LIM;
         case (state_q[i])
            IDLE: begin
               if (grant && allocOH[i])
                  state_d[i] = LAUNCH;
            end
            LAUNCH: begin
               if (tank_death) begin
                  state_d[i] = IDLE;
               end else begin
                  posX_d[i]  = launchX;
                  posY_d[i]  = launchY;
                  dir_d[i]   = last_direction;
                  age_d[i]   = '0;
                  state_d[i] = FLY;
               end
            end
            FLY: begin
               if (tank_death || hit[i]) begin
                  state_d[i] = IDLE;
               end else if (startOfFrame) begin
                  case (dir_q[i])
                     2'd0:    nextPos = posY_q[i] - Y_STEP;
                     2'd1:    nextPos = posX_q[i] - X_STEP;
                     2'd2:    nextPos = posY_q[i] + Y_STEP;
                     default: nextPos = posX_q[i] + X_STEP;
                  endcase
                  if (nextPos[POS_W-1] || (nextPos >= limit)) begin
                     state_d[i] = IDLE;
                  end else begin
                     if (dir_q[i][0])
                        posX_d[i] = nextPos;
                     else
                        posY_d[i] = nextPos;
                     age_d[i] = age_q[i] + 1'b1;
                     if ((LIFETIME_FRAMES != 0) && (age_q[i] == AGE_W'(LIFETIME_FRAMES - 1)))
                        state_d[i] = IDLE;
                  end
               end
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // State registers for the pool, edge detector and cooldown.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shoot_q    <= 1'b0;
         cooldown_q <= '0;
         for (int i = 0; i < NUM_ROCKETS; i++) begin
            state_q[i] <= IDLE;
            posX_q[i]  <= '0;
            posY_q[i]  <= '0;
            dir_q[i]   <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         shoot_q    <= shoot;
         cooldown_q <= cooldown_d;
         for (int i = 0; i < NUM_ROCKETS; i++) begin
            state_q[i] <= state_d[i];
            posX_q[i]  <= posX_d[i];
            posY_q[i]  <= posY_d[i];
            dir_q[i]   <= dir_d[i];
            age_q[i]   <= age_d[i];
         end
      end
   end

   // Pixel outputs are the floor of the fixed-point position.
   always_comb begin
      topLeftX      = '0;
      topLeftY      = '0;
      direction     = '0;
      rocket_enable = '0;
      launching     = '0;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
         topLeftX[11*i +: 11] = posX_q[i][FRAC_BITS +: 11];
         topLeftY[11*i +: 11] = posY_q[i][FRAC_BITS +: 11];
         direction[2*i +: 2]  = dir_q[i];
         rocket_enable[i]     = (state_q[i] == FLY);
         launching[i]         = (state_q[i] == LAUNCH);
      end
   end

endmodule

// File: tb/tb_rocket_pool_move.sv
// Scoreboarded bench for rocket_pool_move: expected launches are queued when
// a shot is driven and checked when the DUT acknowledges it.
module tb_rocket_pool_move;

   localparam int NR     = 4;
   localparam int FRAC   = 6;
   localparam int XSP    = 100;
   localparam int YSP    = 100;
   localparam int MUZZLE = 12;

   typedef struct {
      int slot;
      int x;
      int y;
      int dir;
   } launchExp_t;

   logic              clk;
   logic              resetN;
   logic              startOfFrame;
   logic              shoot;
   logic [1:0]        last_direction;
   logic [10:0]       tankX;
   logic [10:0]       tankY;
   logic [NR-1:0]     hit;
   logic              tank_death;
   logic [11*NR-1:0]  topLeftX;
   logic [11*NR-1:0]  topLeftY;
   logic [2*NR-1:0]   direction;
   logic [NR-1:0]     rocket_enable;
   logic              fire_ack;
   logic              pool_full;

   launchExp_t sb[$];
   int         checkCount = 0;
   int         failCount  = 0;
   int         ackCount   = 0;
   bit         pendingLaunch = 0;

   rocket_pool_move dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .shoot          (shoot),
      .last_direction (last_direction),
      .tankX          (tankX),
      .tankY          (tankY),
      .hit            (hit),
      .tank_death     (tank_death),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .direction      (direction),
      .rocket_enable  (rocket_enable),
      .fire_ack       (fire_ack),
      .pool_full      (pool_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int slotX(input int s);
      return int'(topLeftX[11*s +: 11]);
   endfunction

   function automatic int slotY(input int s);
      return int'(topLeftY[11*s +: 11]);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Every ack must match a queued launch; one cycle later the slot must be
   // flying at the muzzle position with the latched heading.
   always @(negedge clk) begin
      launchExp_t e;
      if (pendingLaunch) begin
         pendingLaunch = 0;
         e = sb.pop_front();
         checkOutput("launchEnable", 32'(rocket_enable[e.slot]), 1);
         checkOutput("launchX", slotX(e.slot), e.x);
         checkOutput("launchY", slotY(e.slot), e.y);
         checkOutput("launchDir", 32'(direction[2*e.slot +: 2]), e.dir);
      end
      if (resetN === 1'b1 && fire_ack === 1'b1) begin
         ackCount++;
         checkOutput("ackExpected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0)
            pendingLaunch = 1;
      end
   end

   task automatic doReset();
      resetN         = 1'b0;
      startOfFrame   = 1'b0;
      shoot          = 1'b0;
      hit            = '0;
      tank_death     = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
   endtask

   task automatic runFrames(input int n);
      for (int k = 0; k < n; k++) begin
         startOfFrame = 1'b1;
         @(negedge clk);
         startOfFrame = 1'b0;
      end
   endtask

   // One shoot edge from a given tank pose; queue the launch if it should be granted.
   task automatic applyStimulus(input int tx, input int ty, input int dir, input bit expectGrant, input int slot);
      tankX          = 11'(tx);
      tankY          = 11'(ty);
      last_direction = 2'(dir);
      shoot          = 1'b1;
      if (expectGrant)
         sb.push_back('{slot, tx + MUZZLE, ty + MUZZLE, dir});
      @(negedge clk);
      checkOutput("fireAck", 32'(fire_ack), 32'(expectGrant));
      shoot = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int ack0;
      int py;
      last_direction = 2'd0;
      tankX          = '0;
      tankY          = '0;
      doReset();

      // Reset values
      checkOutput("rstEnable", 32'(rocket_enable), 0);
      checkOutput("rstAck", 32'(fire_ack), 0);
      checkOutput("rstFull", 32'(pool_full), 0);
      checkOutput("rstX", 32'(topLeftX), 0);
      checkOutput("rstY", 32'(topLeftY), 0);
      checkOutput("rstDir", 32'(direction), 0);

      // Single shot to the right, then 64 frames of motion
      applyStimulus(100, 200, 3, 1, 0);
      runFrames(64);
      checkOutput("flyX64", slotX(0), ((112 << FRAC) + 64 * XSP) >> FRAC);
      checkOutput("flyY64", slotY(0), 212);
      checkOutput("flyEn", 32'(rocket_enable), 1);

      // Held button fires once, then fill the pool
      doReset();
      tankX = 11'd100; tankY = 11'd200; last_direction = 2'd3;
      ack0  = ackCount;
      shoot = 1'b1;
      sb.push_back('{0, 112, 212, 3});
      repeat (1000) @(negedge clk);
      checkOutput("heldOnce", ackCount - ack0, 1);
      shoot = 1'b0;
      @(negedge clk);
      runFrames(8);
      applyStimulus(150, 200, 2, 1, 1);
      runFrames(8);
      applyStimulus(300, 200, 1, 1, 2);
      runFrames(8);
      applyStimulus(300, 300, 0, 1, 3);
      checkOutput("poolFull", 32'(pool_full), 1);
      runFrames(8);
      applyStimulus(300, 300, 0, 0, 0);
      checkOutput("fullEnables", 32'(rocket_enable), 4'hF);

      // Cooldown boundary: refused at 3 and 7 frames, granted at 8
      doReset();
      applyStimulus(100, 100, 3, 1, 0);
      runFrames(3);
      applyStimulus(100, 100, 3, 0, 1);
      runFrames(4);
      applyStimulus(100, 100, 3, 0, 1);
      runFrames(1);
      applyStimulus(100, 150, 2, 1, 1);

      // Exit through the top edge keeps the last in-bounds pixel
      doReset();
      applyStimulus(50, 0, 0, 1, 0);
      py = (0 + MUZZLE) << FRAC;
      runFrames(7);
      py = py - 7 * YSP;
      checkOutput("edgeEnBefore", 32'(rocket_enable[0]), 1);
      checkOutput("edgeYBefore", slotY(0), py >> FRAC);
      runFrames(1);
      checkOutput("edgeEnAfter", 32'(rocket_enable[0]), 0);
      checkOutput("edgeYHold", slotY(0), py >> FRAC);
      checkOutput("edgeXHold", slotX(0), 62);

      // Hit with frame tick on slot 1 while a shot arrives: shot goes to slot 2
      doReset();
      applyStimulus(100, 200, 3, 1, 0);
      runFrames(8);
      applyStimulus(200, 100, 2, 1, 1);
      runFrames(8);
      py = ((100 + MUZZLE) << FRAC) + 8 * YSP;
      tankX = 11'd400; tankY = 11'd50; last_direction = 2'd1;
      hit = 4'b0010;
      startOfFrame = 1'b1;
      shoot = 1'b1;
      sb.push_back('{2, 412, 62, 1});
      @(negedge clk);
      checkOutput("hitAck", 32'(fire_ack), 1);
      checkOutput("hitEn1", 32'(rocket_enable[1]), 0);
      checkOutput("hitY1", slotY(1), py >> FRAC);
      checkOutput("hitX1", slotX(1), 212);
      hit = '0;
      startOfFrame = 1'b0;
      shoot = 1'b0;
      @(negedge clk);

      // Tank death with a simultaneous shoot edge
      runFrames(8);
      applyStimulus(100, 200, 3, 1, 1);
      checkOutput("threeFlying", 32'(rocket_enable), 4'b0111);
      runFrames(2);
      tank_death = 1'b1;
      shoot = 1'b1;
      @(negedge clk);
      checkOutput("deathAck", 32'(fire_ack), 0);
      tank_death = 1'b0;
      shoot = 1'b0;
      @(negedge clk);
      checkOutput("deathEnables", 32'(rocket_enable), 0);
      checkOutput("deathFull", 32'(pool_full), 0);
      applyStimulus(120, 220, 3, 1, 0);

      // Asynchronous reset mid-flight
      #2 resetN = 1'b0;
      #1;
      checkOutput("asyncRstEn", 32'(rocket_enable), 0);
      checkOutput("asyncRstX", slotX(0), 0);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);

      checkOutput("sbDrained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
